// File: rtl/mac_job_sched.sv
// Dot-product job sequencer: streams operand RAM reads into the shared MAC and captures the result.
// Optional abort port pair enabled by defining MAC_JOB_SCHED_ABORT_EN.
module mac_job_sched #(
   parameter int DATA_W = 10,
   parameter int ACC_W  = 2 * DATA_W,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [LEN_W-1:0]  len,
`ifdef MAC_JOB_SCHED_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic              mac_clr,
   output logic              mac_en,
   input  logic [ACC_W-1:0]  mac_acc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN1,
      S_DRAIN2,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base_a_q, base_b_q;
   logic [LEN_W-1:0]  cnt;
   logic              abort_hit;

`ifdef MAC_JOB_SCHED_ABORT_EN
   assign abort_hit = abort && (state inside {S_CLEAR, S_FETCH, S_DRAIN1, S_DRAIN2});
`else
   assign abort_hit = 1'b0;
`endif

   // Strobes decode directly from state so they are glitch-free of start and zero in reset.
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign rd_en   = (state == S_FETCH);
   assign mac_clr = (state == S_CLEAR);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = (len == '0) ? S_DONE : S_CLEAR;
         S_CLEAR:  state_nx = S_FETCH;
         S_FETCH:  if (cnt == LEN_W'(1)) state_nx = S_DRAIN1;
         S_DRAIN1: state_nx = S_DRAIN2;
         S_DRAIN2: state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort_hit) state_nx = S_IDLE;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         base_a_q <= '0;
         base_b_q <= '0;
         cnt      <= '0;
         addr_a   <= '0;
         addr_b   <= '0;
         result   <= '0;
         mac_en   <= 1'b0;
      end else begin
         state  <= state_nx;
         // Operands appear on the RAM outputs one cycle after the read strobe.
         mac_en <= rd_en && !abort_hit;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_a_q <= base_a;
                  base_b_q <= base_b;
                  cnt      <= len;
                  if (len == '0) result <= '0;
               end
            end
            S_CLEAR: begin
               addr_a <= base_a_q;
               addr_b <= base_b_q;
            end
            S_FETCH: begin
               addr_a <= addr_a + 1'b1;
               addr_b <= addr_b + 1'b1;
               cnt    <= cnt - 1'b1;
            end
            S_DRAIN2: begin
               if (!abort_hit) result <= mac_acc;
            end
            default: ;
         endcase
      end
   end

`ifdef MAC_JOB_SCHED_ABORT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) aborted <= 1'b0;
      else     aborted <= abort_hit;
   end
`endif

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed bench for mac_job_sched with behavioural operand RAMs and MAC accumulator.
module tb_mac_job_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_a, base_b, len;
   logic        busy, done, rd_en, mac_clr, mac_en;
   logic [19:0] result, mac_acc;
   logic [7:0]  addr_a, addr_b;
`ifdef MAC_JOB_SCHED_ABORT_EN
   logic        abort, aborted;
`endif

   int n_vec = 0;
   int n_err = 0;

   mac_job_sched dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .base_a  (base_a),
      .base_b  (base_b),
      .len     (len),
`ifdef MAC_JOB_SCHED_ABORT_EN
      .abort   (abort),
      .aborted (aborted),
`endif
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_en   (rd_en),
      .addr_a  (addr_a),
      .addr_b  (addr_b),
      .mac_clr (mac_clr),
      .mac_en  (mac_en),
      .mac_acc (mac_acc)
   );

   always #5 clk = ~clk;

   // Operand RAMs (1-cycle read latency) and the MAC accumulator.
   logic [9:0]  mem_a [256];
   logic [9:0]  mem_b [256];
   logic [9:0]  qa, qb;
   logic [19:0] acc = '0;
   assign mac_acc = acc;

   always @(posedge clk) begin
      if (rd_en) begin
         qa <= mem_a[addr_a];
         qb <= mem_b[addr_b];
      end
      if (mac_clr)     acc <= '0;
      else if (mac_en) acc <= acc + qa * qb;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int first_rd, last_rd, n_rd, first_mac, last_mac, n_mac, n_clr, clr_cyc, overlap, done_cyc;
   logic [7:0] log_a[$], log_b[$];

   // Cycle index 0 is the cycle in which start is presented; sampled on negedges.
   task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                          input int inj_cyc, input logic [7:0] inj_len);
      first_rd = -1; last_rd = -1; n_rd = 0;
      first_mac = -1; last_mac = -1; n_mac = 0;
      n_clr = 0; clr_cyc = -1; overlap = 0; done_cyc = -1;
      log_a.delete(); log_b.delete();
      @(negedge clk);
      base_a = ba; base_b = bb; len = ln; start = 1'b1;
      for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         start = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            len = inj_len; base_a = 8'd200; base_b = 8'd200;
         end
         if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc; n_rd++;
            log_a.push_back(addr_a); log_b.push_back(addr_b);
         end
         if (mac_en) begin
            if (first_mac < 0) first_mac = cyc;
            last_mac = cyc; n_mac++;
         end
         if (mac_clr) begin
            n_clr++; clr_cyc = cyc;
         end
         if (mac_clr && mac_en) overlap++;
         if (done) done_cyc = cyc;
      end
      start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   initial begin
      int n_done;
      rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0; len = '0;
`ifdef MAC_JOB_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0; mem_b[i] = '0;
      end
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 10'(i + 1); mem_b[i] = 10'(i + 5);
      end
      mem_a[100] = 10'd1023; mem_b[100] = 10'd1023;
      mem_a[110] = 10'd1; mem_a[111] = 10'd1;
      mem_b[110] = 10'd1; mem_b[111] = 10'd1;
      mem_a[254] = 10'd3; mem_a[255] = 10'd4;
      mem_b[10] = 10'd1; mem_b[11] = 10'd2; mem_b[12] = 10'd3; mem_b[13] = 10'd4;

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_strobes", {rd_en, mac_clr, mac_en}, 0);
      check("rst_addr", {addr_a, addr_b}, 0);
      check("rst_result", result, 0);
      rst = 1'b0;

      // Basic dot product {1,2,3,4}.{5,6,7,8}
      run_job(8'd0, 8'd0, 8'd4, 0, 8'd0);
      check("j1_clr_cycle", clr_cyc, 1);
      check("j1_clr_count", n_clr, 1);
      check("j1_rd_first", first_rd, 2);
      check("j1_rd_last", last_rd, 5);
      check("j1_rd_count", n_rd, 4);
      check("j1_mac_first", first_mac, 3);
      check("j1_mac_last", last_mac, 6);
      check("j1_mac_count", n_mac, 4);
      check("j1_clr_en_overlap", overlap, 0);
      check("j1_done_cycle", done_cyc, 8);
      check("j1_result", result, 70);

      // Zero-length job
      run_job(8'd5, 8'd5, 8'd0, 0, 8'd0);
      check("len0_done_cycle", done_cyc, 1);
      check("len0_result", result, 0);
      check("len0_strobes", n_rd + n_mac + n_clr, 0);

      // Full-scale product, then a small job proving the clear
      run_job(8'd100, 8'd100, 8'd1, 0, 8'd0);
      check("max_done_cycle", done_cyc, 5);
      check("max_result", result, 1046529);
      run_job(8'd110, 8'd110, 8'd2, 0, 8'd0);
      check("clr_result", result, 2);
      check("clr_mac_count", n_mac, 2);

      // Address wrap on A
      run_job(8'd254, 8'd10, 8'd4, 0, 8'd0);
      check("wrap_count", log_a.size(), 4);
      check("wrap_a0", log_a[0], 254);
      check("wrap_a1", log_a[1], 255);
      check("wrap_a2", log_a[2], 0);
      check("wrap_a3", log_a[3], 1);
      check("wrap_b0", log_b[0], 10);
      check("wrap_b3", log_b[3], 13);
      check("wrap_result", result, 22);

      // start pulsed during FETCH is ignored
      run_job(8'd0, 8'd0, 8'd4, 3, 8'd2);
      check("inj_rd_count", n_rd, 4);
      check("inj_first_addr", log_a[0], 0);
      check("inj_done_cycle", done_cyc, 8);
      check("inj_result", result, 70);

`ifdef MAC_JOB_SCHED_ABORT_EN
      @(negedge clk);
      base_a = '0; base_b = '0; len = 8'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); abort = 1'b1;
      check("ab_pre_rd", rd_en, 1);
      @(negedge clk); abort = 1'b0;
      check("ab_aborted", aborted, 1);
      check("ab_idle", busy, 0);
      check("ab_strobes", {rd_en, mac_en}, 0);
      check("ab_result_kept", result, 70);
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("ab_no_done", n_done, 0);
      check("ab_pulse_end", aborted, 0);
`endif

      // Asynchronous reset in the middle of FETCH
      @(negedge clk);
      base_a = '0; base_b = '0; len = 8'd8; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rd_pre", rd_en, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_busy", busy, 0);
      check("mid_strobes", {rd_en, mac_en, mac_clr, done}, 0);
      check("mid_addr", {addr_a, addr_b}, 0);
      check("mid_result", result, 0);
      @(negedge clk); rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("mid_no_done", n_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mac_job_sched.md
Name: mac_job_sched

Overview:
- Sequencer for the shared 10x10 multiply-accumulate datapath.
- Accepts a dot-product job: operand A/B base addresses and length.
- Streams operand reads from two single-port operand RAMs (1-cycle read latency), drives the MAC's clear/enable, captures the final accumulator and signals completion.
- Sits between the host/control FSM and the MAC unit.

Parameters:
- DATA_W, 10, operand width (MAC input width)
- ACC_W, 20, accumulator/result width (2*DATA_W)
- ADDR_W, 8, operand RAM address width
- LEN_W, 8, job length field width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- base_a  in  ADDR_W  first A operand address
- base_b  in  ADDR_W  first B operand address
- len  in  LEN_W  number of products to accumulate
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  ACC_W  captured dot product; held until next capture
- rd_en  out  1  operand RAM read strobe (both RAMs)
- addr_a  out  ADDR_W  A RAM address
- addr_b  out  ADDR_W  B RAM address
- mac_clr  out  1  synchronous accumulator clear to MAC
- mac_en  out  1  MAC accumulate enable; operands valid on RAM outputs
- mac_acc  in  ACC_W  MAC accumulator value; updated the cycle after mac_en

Behaviour:
- Reset: asynchronous on rst; state=IDLE. busy, done, rd_en, mac_clr and mac_en are 0. addr_a, addr_b, result and the internal count are 0.
- FSM states and transitions:
  - IDLE: on start=1 latch base_a, base_b and len.
    - len!=0 -> CLEAR.
    - len==0 -> DONE with result=0, no rd_en/mac_en issued.
  - CLEAR: mac_clr=1 for exactly one cycle; addr_a/addr_b loaded with the bases -> FETCH.
  - FETCH: rd_en=1 every cycle. addr_a/addr_b increment by 1 per cycle, wrapping modulo 2^ADDR_W. Lasts exactly len cycles -> DRAIN1.
  - DRAIN1: rd_en=0; last mac_en is issued -> DRAIN2.
  - DRAIN2: wait for the accumulator update; at the end of this cycle result<=mac_acc -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- mac_en is rd_en delayed by one register stage. It is high for exactly len cycles per job; mac_clr and mac_en are never high together.
- Latency: start accepted in cycle S gives CLEAR at S+1, FETCH at S+2..S+1+len, DRAIN1 at S+2+len, DRAIN2 at S+3+len, done high at S+4+len.
- The len==0 job gives done high at S+1.
- Back-to-back: start high in the DONE cycle is ignored. It is sampled again in the following IDLE cycle, so the minimum job-to-job spacing is one IDLE cycle.
- start while busy: ignored and not queued; latched job fields are unaffected.
- Width: result is mac_acc verbatim (no saturation). Overflow beyond ACC_W wraps inside the MAC and is not flagged.
- Reset mid-job: immediate return to IDLE. Outputs take their reset values; no done pulse; result is cleared.

Optional Feature:
- Macro: MAC_JOB_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in CLEAR, FETCH, DRAIN1 or DRAIN2 forces IDLE on the next edge.
  - rd_en and mac_en drop on that edge.
  - No done pulse; result keeps its previous value.
  - aborted pulses high for one cycle.
  - abort in IDLE or DONE has no effect; in DONE the done pulse still occurs.
- Not defined: ports absent; behaviour as above.

Test Plan:
- A RAM={1,2,3,4}, B RAM={5,6,7,8}, base 0/0, len=4, start at S -> rd_en high S+2..S+5, mac_en S+3..S+6, done at S+8, result=70.
- len=0 start -> done at S+1, result=0, rd_en/mac_en/mac_clr never asserted.
- A=B=1023, len=1 -> result=1046529; second job len=2 with A={1,1}, B={1,1} -> result=2, proving mac_clr reset the accumulator.
- base_a=254, base_b=10, len=4 -> addr_a sequence 254,255,0,1; addr_b sequence 10,11,12,13.
- Pulse start during FETCH with different len -> ignored; original job completes with the original length.
- rst asserted mid-FETCH -> outputs zero asynchronously, no done. With MAC_JOB_SCHED_ABORT_EN: abort in FETCH -> aborted pulse, IDLE next cycle, result unchanged.
